// File: rtl/mtimecmp_programmer.sv
// Bus initiator that programs the machine-timer compare register.
// Absolute or mtime-relative target; glitch-free three-write sequence when SAFE_SEQ=1.
module mtimecmp_programmer #(
  parameter int unsigned SAFE_SEQ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        abs_i,
  input  logic [63:0] value_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] cmp_o,
  output logic        en_o,
  output logic [3:0]  addr_o,
  output logic [7:0]  we_o,
  output logic [63:0] data_o,
  input  logic [63:0] data_i
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_LO_MAX, WR_HI, WR_LO, WR_64, DONE
  } state_t;

  typedef struct packed {
    logic        en;
    logic [3:0]  addr;
    logic [7:0]  we;
    logic [63:0] data;
  } bus_t;

  localparam state_t WR_FIRST = state_t'((SAFE_SEQ != 0) ? WR_LO_MAX : WR_64);

  state_t      state;
  bus_t        bus_q;
  logic [63:0] target_q;
  logic [63:0] delta_q;
  logic [63:0] rel_target;

  // Bus fields for the state being entered, so the outputs are registered
  // yet line up with the state they belong to.
  function automatic bus_t bus_for(input state_t s, input logic [63:0] t);
    bus_t b;
    b = '0;
    case (s)
      RD_ISSUE: begin
        b.en   = 1'b1;
        b.addr = 4'h0;
      end
      WR_LO_MAX: begin
        b.en   = 1'b1;
        b.addr = 4'h8;
        b.we   = 8'h0F;
        b.data = {32'h0, 32'hFFFF_FFFF};
      end
      WR_HI: begin
        b.en   = 1'b1;
        b.addr = 4'hC;
        b.we   = 8'h0F;
        b.data = {32'h0, t[63:32]};
      end
      WR_LO: begin
        b.en   = 1'b1;
        b.addr = 4'h8;
        b.we   = 8'h0F;
        b.data = {32'h0, t[31:0]};
      end
      WR_64: begin
        b.en   = 1'b1;
        b.addr = 4'h8;
        b.we   = 8'hFF;
        b.data = t;
      end
      default: b = '0;
    endcase
    return b;
  endfunction

  // Carry out of bit 63 is dropped: the compare value wraps with mtime.
  always_comb begin
    rel_target = data_i + delta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bus_q    <= '0;
      target_q <= '0;
      delta_q  <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      cmp_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            busy_o <= 1'b1;
            if (abs_i) begin
              target_q <= value_i;
              state    <= WR_FIRST;
              bus_q    <= bus_for(WR_FIRST, value_i);
            end else begin
              delta_q <= value_i;
              state   <= RD_ISSUE;
              bus_q   <= bus_for(RD_ISSUE, '0);
            end
          end
        end
        RD_ISSUE: begin
          state <= RD_WAIT;
          bus_q <= '0;
        end
        RD_WAIT: begin
          target_q <= rel_target;
          state    <= WR_FIRST;
          bus_q    <= bus_for(WR_FIRST, rel_target);
        end
        WR_LO_MAX: begin
          state <= WR_HI;
          bus_q <= bus_for(WR_HI, target_q);
        end
        WR_HI: begin
          state <= WR_LO;
          bus_q <= bus_for(WR_LO, target_q);
        end
        WR_LO, WR_64: begin
          state  <= DONE;
          bus_q  <= '0;
          done_o <= 1'b1;
          cmp_o  <= target_q;
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
          bus_q <= '0;
        end
      endcase
    end
  end

  assign en_o   = bus_q.en;
  assign addr_o = bus_q.addr;
  assign we_o   = bus_q.we;
  assign data_o = bus_q.data;

endmodule

// File: tb/tb_mtimecmp_programmer.sv
// Bench for mtimecmp_programmer: one SAFE_SEQ=1 and one SAFE_SEQ=0 instance,
// each against its own timer responder, checked against a transaction-level timeline.
module tb_mtimecmp_programmer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req [2];
  logic        abs_v;
  logic [63:0] value_v;
  logic        busy [2];
  logic        done [2];
  logic [63:0] cmp [2];
  logic        en [2];
  logic [3:0]  addr [2];
  logic [7:0]  we [2];
  logic [63:0] wdata [2];
  logic [63:0] rdata [2];

  logic [63:0] mtime = '0;
  logic        load;
  logic [63:0] load_val;
  logic [63:0] mtimecmp [2];
  logic        mti [2];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned opn = 0;
  logic [63:0] prev_cmp [2];

  always #5 clk = ~clk;

  mtimecmp_programmer #(.SAFE_SEQ(1)) u_dut_safe (
    .clk(clk), .reset(reset), .req_i(req[0]), .abs_i(abs_v), .value_i(value_v),
    .busy_o(busy[0]), .done_o(done[0]), .cmp_o(cmp[0]), .en_o(en[0]),
    .addr_o(addr[0]), .we_o(we[0]), .data_o(wdata[0]), .data_i(rdata[0])
  );

  mtimecmp_programmer #(.SAFE_SEQ(0)) u_dut_fast (
    .clk(clk), .reset(reset), .req_i(req[1]), .abs_i(abs_v), .value_i(value_v),
    .busy_o(busy[1]), .done_o(done[1]), .cmp_o(cmp[1]), .en_o(en[1]),
    .addr_o(addr[1]), .we_o(we[1]), .data_o(wdata[1]), .data_i(rdata[1])
  );

  // Timer slave: free-running mtime, registered read data, 32/64-bit compare writes.
  initial begin
    mtimecmp[0] = '1;
    mtimecmp[1] = '1;
    rdata[0] = '0;
    rdata[1] = '0;
  end

  always @(posedge clk) begin
    mtime <= load ? load_val : mtime + 64'd1;
    for (int i = 0; i < 2; i++) begin
      if (en[i] && we[i] == 8'h00) rdata[i] <= mtime;
      else if (en[i] && we[i] == 8'hFF) mtimecmp[i] <= wdata[i];
      else if (en[i] && we[i] == 8'h0F && addr[i] == 4'h8) mtimecmp[i][31:0] <= wdata[i][31:0];
      else if (en[i] && we[i] == 8'h0F && addr[i] == 4'hC) mtimecmp[i][63:32] <= wdata[i][31:0];
    end
  end

  always_comb begin
    mti[0] = (mtime >= mtimecmp[0]);
    mti[1] = (mtime >= mtimecmp[1]);
  end

  task automatic check(input string tag, input logic [142:0] observed, input logic [142:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  function automatic logic [142:0] obs(input int unsigned i);
    return {en[i], addr[i], we[i], wdata[i], busy[i], done[i], cmp[i]};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // One request held for `hold` sampling edges. The expected timeline is built
  // from the transaction rules: optional read, then the write list, then DONE.
  task automatic run_op(input int unsigned idx, input logic is_abs, input logic [63:0] value,
                        input logic [63:0] mt, input int unsigned hold);
    logic [76:0] eb [32];
    logic        ebusy [32];
    logic        edone [32];
    logic [63:0] ecmp [32];
    logic [63:0] tgt;
    logic        safe;
    int unsigned d, b, nf, last;
    safe = (idx == 0);
    d = (is_abs ? 0 : 2) + (safe ? 3 : 1) + 1;
    for (int k = 0; k < 32; k++) begin
      eb[k] = '0;
      ebusy[k] = 1'b0;
      edone[k] = 1'b0;
      ecmp[k] = prev_cmp[idx];
    end
    nf = 0;
    for (int unsigned e = 0; e < hold; e++) begin
      if (e >= nf) begin
        tgt = is_abs ? value : mt + value;
        b = e + 1;
        if (!is_abs) begin
          eb[b] = {1'b1, 4'h0, 8'h00, 64'h0};
          b += 2;
        end
        if (safe) begin
          eb[b]     = {1'b1, 4'h8, 8'h0F, 32'h0, 32'hFFFF_FFFF};
          eb[b + 1] = {1'b1, 4'hC, 8'h0F, 32'h0, tgt[63:32]};
          eb[b + 2] = {1'b1, 4'h8, 8'h0F, 32'h0, tgt[31:0]};
        end else begin
          eb[b] = {1'b1, 4'h8, 8'hFF, tgt};
        end
        for (int unsigned k = e + 1; k <= e + d; k++) ebusy[k] = 1'b1;
        edone[e + d] = 1'b1;
        for (int unsigned k = e + d; k < 32; k++) ecmp[k] = tgt;
        nf = e + d + 1;
      end
    end
    last = (nf > hold) ? nf : hold;
    @(negedge clk);
    req[idx] = 1'b1;
    abs_v = is_abs;
    value_v = value;
    load = 1'b1;
    load_val = mt;
    for (int unsigned k = 1; k <= last; k++) begin
      @(negedge clk);
      check($sformatf("op%0d_dut%0d_c%0d", opn, idx, k), obs(idx),
            {eb[k], ebusy[k], edone[k], ecmp[k]});
      if (k == 1) load = 1'b0;
      if (k == hold) begin
        req[idx] = 1'b0;
        abs_v = 1'($urandom);
        value_v = rand64();
      end
    end
    prev_cmp[idx] = ecmp[last];
    opn++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    abs_v = 1'b0;
    value_v = '0;
    load = 1'b0;
    load_val = '0;
    prev_cmp[0] = '0;
    prev_cmp[1] = '0;
    repeat (3) @(negedge clk);
    check("reset_safe", obs(0), '0);
    check("reset_fast", obs(1), '0);
    reset = 1'b0;
    @(negedge clk);

    run_op(0, 1'b1, 64'h0000_0001_0000_0010, rand64(), 1);
    check("abs_cmp", {79'h0, cmp[0]}, {79'h0, 64'h0000_0001_0000_0010});

    run_op(0, 1'b0, 64'd100, 64'h1F4, 1);
    check("rel_cmp", {79'h0, cmp[0]}, {79'h0, 64'h258});
    check("mti_early", {142'h0, mti[0]}, 143'h0);
    for (int n = 0; n < 200 && !mti[0]; n++) @(negedge clk);
    check("mti_rise", {78'h0, mti[0], mtime}, {78'h0, 1'b1, 64'h258});

    run_op(0, 1'b0, 64'h20, 64'hFFFF_FFFF_FFFF_FFF0, 1);
    check("wrap_cmp", {79'h0, cmp[0]}, {79'h0, 64'h10});

    run_op(1, 1'b1, 64'hDEAD_BEEF_0000_0000, rand64(), 1);
    run_op(1, 1'b0, 64'h0, rand64(), 1);
    run_op(0, 1'b0, 64'h0, rand64(), 1);
    run_op(0, 1'b1, rand64(), rand64(), 10);
    run_op(1, 1'b1, rand64(), rand64(), 6);

    // Reset pulse while the high word is on the bus.
    @(negedge clk);
    req[0] = 1'b1;
    abs_v = 1'b1;
    value_v = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    req[0] = 1'b0;
    check("rst_c1", {138'h0, en[0], addr[0]}, {138'h0, 1'b1, 4'h8});
    @(negedge clk);
    check("rst_c2", {138'h0, en[0], addr[0]}, {138'h0, 1'b1, 4'hC});
    #1 reset = 1'b1;
    #1 check("rst_async", obs(0), '0);
    @(negedge clk);
    reset = 1'b0;
    prev_cmp[0] = '0;
    prev_cmp[1] = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_quiet%0d", k), obs(0), '0);
    end
    check("rst_lo_max", {111'h0, mtimecmp[0][31:0]}, {111'h0, 32'hFFFF_FFFF});
    run_op(0, 1'b1, 64'h0000_00AB_0000_00CD, rand64(), 1);

    for (int n = 0; n < 12; n++) begin
      run_op(n % 2, 1'($urandom), rand64(), rand64(), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
